// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// remainder to HI and quotient to LO, with a one-shot HI/LO write strobe.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    output logic             ready_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    counter_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] divisor_r;
    logic             neg1_r;
    logic             neg2_r;
    logic             ready_r;
    logic             hilo_we_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             neg1_s;
    logic             neg2_s;
    logic [WIDTH-1:0] abs1_s;
    logic [WIDTH-1:0] abs2_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             fits_s;
    logic             end_hold_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    assign neg1_s = signed_div_i & opdata1_i[WIDTH-1];
    assign neg2_s = signed_div_i & opdata2_i[WIDTH-1];
    assign abs1_s = neg1_s ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
    assign abs2_s = neg2_s ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;

    // A clear top bit of the W+1-bit difference means no borrow: the divisor fits.
    assign rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    assign diff_s      = rem_shift_s - {1'b0, divisor_r};
    assign fits_s      = ~diff_s[WIDTH];

    assign quo_fix_s  = (neg1_r ^ neg2_r) ? ({WIDTH{1'b0}} - quo_r) : quo_r;
    assign rem_fix_s  = neg1_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
    assign end_hold_s = (state_r == END) && (state_next_s == END);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FREE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the first END cycle always publishes unless annulled.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FREE: begin
                if (start_i && !annul_i) begin
                    state_next_s = (opdata2_i == {WIDTH{1'b0}}) ? BYZERO : ON;
                end else begin
                    state_next_s = FREE;
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_next_s = FREE;
                end else begin
                    state_next_s = END;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_next_s = FREE;
                end else if (counter_r == LAST_STEP) begin
                    state_next_s = END;
                end else begin
                    state_next_s = ON;
                end
            end
            END: begin
                if (annul_i || (ready_r && !start_i)) begin
                    state_next_s = FREE;
                end else begin
                    state_next_s = END;
                end
            end
            default: state_next_s = FREE;
        endcase
    end

    // Operand capture and one restoring step per ON cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_r <= {CW{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            neg1_r    <= 1'b0;
            neg2_r    <= 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    if (state_next_s != FREE) begin
                        counter_r <= {CW{1'b0}};
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= abs1_s;
                        divisor_r <= abs2_s;
                        neg1_r    <= neg1_s;
                        neg2_r    <= neg2_s;
                    end
                end
                BYZERO: begin
                    rem_r <= {WIDTH{1'b0}};
                    quo_r <= {WIDTH{1'b0}};
                end
                ON: begin
                    rem_r     <= fits_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
                    quo_r     <= {quo_r[WIDTH-2:0], fits_s};
                    counter_r <= counter_r + CW'(1);
                end
                default: begin
                    counter_r <= counter_r;
                end
            endcase
        end
    end

    // Registered result outputs; HI/LO only change on the first published END cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r   <= 1'b0;
            hilo_we_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            ready_r   <= end_hold_s;
            hilo_we_r <= end_hold_s && !ready_r;
            if (end_hold_s && !ready_r) begin
                hi_r <= rem_fix_s;
                lo_r <= quo_fix_s;
            end
        end
    end

    assign ready_o   = ready_r;
    assign hilo_we_o = hilo_we_r;
    assign hi_o      = hi_r;
    assign lo_o      = lo_r;

endmodule
